// File: rtl/tx_transmitter_if.sv
// rtl/tx_transmitter_if.sv - frame request / serial line bundle for tx_transmitter
// Signals:
//   start    frame request, accepted only while busy=0
//   dest_id  destination id (2 bits)
//   src_id   source id (2 bits)
//   length   payload length minus 1 (4 bits, 1..16 bytes sent)
//   payload  payload data, low 8*(length+1) bits are sent highest bit first
//   tx_line  registered serial line output
//   busy     frame in progress, including the trailing gap
//   done     one-cycle pulse after the last gap bit
interface tx_transmitter_if;
    logic         start;
    logic [1:0]   dest_id;
    logic [1:0]   src_id;
    logic [3:0]   length;
    logic [127:0] payload;
    logic         tx_line;
    logic         busy;
    logic         done;

    modport master (
        output start, dest_id, src_id, length, payload,
        input  tx_line, busy, done
    );

    modport slave (
        input  start, dest_id, src_id, length, payload,
        output tx_line, busy, done
    );
endinterface

// File: rtl/tx_transmitter.sv
// rtl/tx_transmitter.sv - serial frame transmitter with CRC-8 trailer
// Ports:
//   clk    system clock, one line bit per cycle
//   rst_n  asynchronous active-low reset
//   bus    tx_transmitter_if.slave: start/dest_id/src_id/length/payload in,
//          tx_line/busy/done out
// Frame: 16-bit preamble 0xAAAA, SFD 0xAB, header {dest,src,length},
// length+1 payload bytes, CRC-8 (poly 0x07, init 0x00) over header+payload,
// then GAP_BITS idle zeros. All bits MSB first.
module tx_transmitter #(
    parameter int GAP_BITS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    tx_transmitter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, CRC, GAP
    } state_t;

    localparam logic [23:0] SYNC = {16'hAAAA, 8'hAB};

    state_t         state, state_next;
    logic [7:0]     cnt, cnt_next;
    logic [7:0]     crc, crc_next;
    logic [23:0]    sync_sh;
    logic [7:0]     hdr_sh;
    logic [127:0]   pay_sh;
    logic [3:0]     len_q;
    logic           tx_q, bit_next;
    logic           busy_q, busy_next;
    logic           done_q, done_next;
    logic           accept, shift_sync, shift_hdr, shift_pay;
    logic [7:0]     pay_bits;

    // 8-bit width so length=15 yields 128 without wrapping
    assign pay_bits = ({4'd0, len_q} + 8'd1) << 3;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // Each branch computes the bit that the next edge loads into tx_line;
    // the state therefore names the field of the bit currently on the line.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 8'd1;
        bit_next   = 1'b0;
        crc_next   = crc;
        accept     = 1'b0;
        shift_sync = 1'b0;
        shift_hdr  = 1'b0;
        shift_pay  = 1'b0;
        busy_next  = 1'b1;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                busy_next = 1'b0;
                crc_next  = 8'h00;
                cnt_next  = 8'd0;
                if (bus.start) begin
                    accept     = 1'b1;
                    busy_next  = 1'b1;
                    state_next = PREAMBLE;
                    bit_next   = SYNC[23];
                end
            end
            PREAMBLE: begin
                crc_next   = 8'h00;
                bit_next   = sync_sh[23];
                shift_sync = 1'b1;
                if (cnt == 8'd15) begin
                    state_next = SFD;
                    cnt_next   = 8'd0;
                end
            end
            SFD: begin
                crc_next = 8'h00;
                if (cnt == 8'd7) begin
                    state_next = HEADER;
                    cnt_next   = 8'd0;
                    bit_next   = hdr_sh[7];
                    shift_hdr  = 1'b1;
                    crc_next   = crc_step(8'h00, hdr_sh[7]);
                end else begin
                    bit_next   = sync_sh[23];
                    shift_sync = 1'b1;
                end
            end
            HEADER: begin
                if (cnt == 8'd7) begin
                    state_next = PAYLOAD;
                    cnt_next   = 8'd0;
                    bit_next   = pay_sh[127];
                    shift_pay  = 1'b1;
                    crc_next   = crc_step(crc, pay_sh[127]);
                end else begin
                    bit_next   = hdr_sh[7];
                    shift_hdr  = 1'b1;
                    crc_next   = crc_step(crc, hdr_sh[7]);
                end
            end
            PAYLOAD: begin
                if (cnt == pay_bits - 8'd1) begin
                    // crc already holds the value including the last payload bit
                    state_next = CRC;
                    cnt_next   = 8'd0;
                    bit_next   = crc[7];
                end else begin
                    bit_next   = pay_sh[127];
                    shift_pay  = 1'b1;
                    crc_next   = crc_step(crc, pay_sh[127]);
                end
            end
            CRC: begin
                // crc is frozen here; index it rather than shifting
                if (cnt == 8'd7) begin
                    cnt_next = 8'd0;
                    if (GAP_BITS == 0) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = GAP;
                    end
                end else begin
                    bit_next = crc[3'(3'd6 - cnt[2:0])];
                end
            end
            GAP: begin
                if (cnt == 8'(GAP_BITS - 1)) begin
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            crc     <= 8'h00;
            sync_sh <= 24'd0;
            hdr_sh  <= 8'd0;
            pay_sh  <= 128'd0;
            len_q   <= 4'd0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            crc    <= crc_next;
            tx_q   <= bit_next;
            busy_q <= busy_next;
            done_q <= done_next;
            if (accept) begin
                // first sync bit goes straight to the line, keep the rest
                sync_sh <= SYNC << 1;
                hdr_sh  <= {bus.dest_id, bus.src_id, bus.length};
                // left-align the sent bytes: shift by 8*(15-length)
                pay_sh  <= bus.payload << {~bus.length, 3'b000};
                len_q   <= bus.length;
            end else begin
                if (shift_sync) sync_sh <= sync_sh << 1;
                if (shift_hdr)  hdr_sh  <= hdr_sh << 1;
                if (shift_pay)  pay_sh  <= pay_sh << 1;
            end
        end
    end

    assign bus.tx_line = tx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_tx_transmitter.sv
// tb/tb_tx_transmitter.sv - directed self-checking bench for tx_transmitter
module tb_tx_transmitter;

    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tx_transmitter_if bus();

    tx_transmitter #(.GAP_BITS(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic rec_line [0:255];
    logic rec_busy [0:255];
    logic rec_done [0:255];

    task automatic check(input string tag, input logic [167:0] got, input logic [167:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc_bit(input logic [7:0] c, input logic b);
        logic [7:0] r;
        r = {c[6:0], 1'b0};
        if (c[7] ^ b) r = r ^ 8'h07;
        return r;
    endfunction

    // Expected frame, left-aligned in 168 bits, zeros after the last bit
    function automatic logic [167:0] build_frame(input logic [1:0] d, input logic [1:0] s,
                                                 input logic [3:0] l, input logic [127:0] p);
        logic [167:0] f;
        logic [23:0]  sync;
        logic [7:0]   h;
        logic [7:0]   c;
        int           pos;
        f = '0; pos = 167; c = 8'h00;
        sync = {16'hAAAA, 8'hAB};
        h = {d, s, l};
        for (int i = 23; i >= 0; i--) begin f[pos] = sync[i]; pos--; end
        for (int i = 7; i >= 0; i--) begin f[pos] = h[i]; c = crc_bit(c, h[i]); pos--; end
        for (int i = 8 * (int'(l) + 1) - 1; i >= 0; i--) begin
            f[pos] = p[i]; c = crc_bit(c, p[i]); pos--;
        end
        for (int i = 7; i >= 0; i--) begin f[pos] = c[i]; pos--; end
        return f;
    endfunction

    function automatic logic [167:0] got_window(input int s, input int n);
        logic [167:0] g;
        g = '0;
        for (int i = 0; i < n; i++) g[167 - i] = rec_line[s + i];
        return g;
    endfunction

    // Receiver model: recompute CRC over header+payload, compare with trailer
    function automatic logic rx_crc_ok(input logic [167:0] f, input int l);
        logic [7:0] c;
        logic [7:0] rx;
        int nb;
        c = 8'h00;
        nb = 8 + 8 * (l + 1);
        for (int i = 0; i < nb; i++) c = crc_bit(c, f[167 - 24 - i]);
        for (int i = 0; i < 8; i++) rx[7 - i] = f[167 - 24 - nb - i];
        return (c == rx);
    endfunction

    function automatic logic [127:0] rx_payload(input logic [167:0] f, input int l);
        logic [127:0] p;
        int nb;
        p = '0;
        nb = 8 * (l + 1);
        for (int k = 0; k < nb; k++) p[nb - 1 - k] = f[167 - 32 - k];
        return p;
    endfunction

    // Sample n cycles at negedge; sample 0 is the first bit after the accept edge
    task automatic record(input int n, input int drop_at, input int poke_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rec_line[i] = bus.tx_line;
            rec_busy[i] = bus.busy;
            rec_done[i] = bus.done;
            if (i == drop_at) bus.start = 1'b0;
            if (i == poke_at) begin
                bus.start   = 1'b1;
                bus.dest_id = 2'd3;
                bus.src_id  = 2'd0;
                bus.length  = 4'd7;
                bus.payload = {128{1'b1}};
            end
            if (i == poke_at + 1) bus.start = 1'b0;
        end
    endtask

    task automatic request(input logic [1:0] d, input logic [1:0] s,
                           input logic [3:0] l, input logic [127:0] p);
        bus.dest_id = d;
        bus.src_id  = s;
        bus.length  = l;
        bus.payload = p;
        bus.start   = 1'b1;
    endtask

    function automatic int count_ones(input int from, input int to, input int which);
        int c;
        c = 0;
        for (int i = from; i < to; i++) begin
            if (which == 0 && rec_line[i]) c++;
            if (which == 1 && rec_busy[i]) c++;
            if (which == 2 && rec_done[i]) c++;
        end
        return c;
    endfunction

    function automatic int first_done(input int n);
        for (int i = 0; i < n; i++) if (rec_done[i]) return i;
        return -1;
    endfunction

    logic [127:0] pmax;
    logic [167:0] f;

    initial begin
        bus.start = 1'b0; bus.dest_id = '0; bus.src_id = '0;
        bus.length = '0; bus.payload = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx_line", bus.tx_line, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // minimal frame
        request(2'd2, 2'd1, 4'd0, 128'hA5);
        record(48 + GAP + 4, 0, -10);
        check("min_frame", got_window(0, 48 + GAP),
              {16'hAAAA, 8'hAB, 8'h90, 8'hA5, 8'h93, 120'd0});
        check("min_busy_first", rec_busy[0], 1);
        check("min_busy_last_gap", rec_busy[48 + GAP - 1], 1);
        check("min_busy_drop", rec_busy[48 + GAP], 0);
        check("min_done_idx", first_done(48 + GAP + 4), 48 + GAP);
        check("min_done_count", count_ones(0, 48 + GAP + 4, 2), 1);

        // maximum frame, incrementing bytes
        for (int k = 0; k < 16; k++) pmax[8*k +: 8] = 8'(k);
        request(2'd1, 2'd2, 4'd15, pmax);
        record(168 + GAP + 3, 0, -10);
        f = got_window(0, 168);
        check("max_frame", f, build_frame(2'd1, 2'd2, 4'd15, pmax));
        check("max_rx_valid", rx_crc_ok(f, 15), 1);
        check("max_rx_payload", rx_payload(f, 15), pmax);
        check("max_done_idx", first_done(168 + GAP + 3), 168 + GAP);
        f[167 - 32 - 40] = ~f[167 - 32 - 40];
        check("flip_crc_error", rx_crc_ok(f, 15), 0);

        // start pulsed mid-frame with different fields
        request(2'd1, 2'd3, 4'd2, 128'h123456);
        record(64 + GAP + 30, 0, 19);
        check("busy_start_frame", got_window(0, 64 + GAP),
              build_frame(2'd1, 2'd3, 4'd2, 128'h123456));
        check("busy_start_no_second_line", count_ones(64 + GAP, 64 + GAP + 30, 0), 0);
        check("busy_start_no_second_busy", count_ones(64 + GAP, 64 + GAP + 30, 1), 0);
        check("busy_start_done_count", count_ones(0, 64 + GAP + 30, 2), 1);

        // start held high: three back-to-back frames, length=1
        request(2'd0, 2'd3, 4'd1, 128'hBEEF);
        record(3 * (56 + GAP + 1) + 3, 2 * (56 + GAP + 1), -10);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b_frame%0d", k), got_window(k * (56 + GAP + 1), 56 + GAP + 1),
                  build_frame(2'd0, 2'd3, 4'd1, 128'hBEEF));
            check($sformatf("b2b_done%0d", k), rec_done[k * (56 + GAP + 1) + 56 + GAP], 1);
            check($sformatf("b2b_rx%0d", k), rx_crc_ok(got_window(k * (56 + GAP + 1), 56), 1), 1);
        end
        check("b2b_done_count", count_ones(0, 3 * (56 + GAP + 1) + 3, 2), 3);
        check("b2b_idle_after", rec_busy[3 * (56 + GAP + 1) + 2], 0);

        // asynchronous reset during payload
        request(2'd3, 2'd3, 4'd3, {128{1'b1}});
        record(40, 0, -10);
        check("rst_pre_line", rec_line[39], 1);
        check("rst_pre_busy", rec_busy[39], 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tx_line", bus.tx_line, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        request(2'd2, 2'd1, 4'd0, 128'hA5);
        record(48 + GAP + 2, 0, -10);
        check("post_rst_frame", got_window(0, 48 + GAP),
              {16'hAAAA, 8'hAB, 8'h90, 8'hA5, 8'h93, 120'd0});
        check("post_rst_done_idx", first_done(48 + GAP + 2), 48 + GAP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
